instr_queue: RTL and testbench
==============================

# instr_queue

Decoupling FIFO between the fetch unit and dispatch. It captures every valid fetched instruction with its PC and predicted nPC, and presents entries in order to dispatch under a valid/ready handshake. It exports a full flag to the core controller, which turns it into the fetch-unit stall. The entire contents are discarded when the ROB restarts fetch on a resolved target.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2.
- LOG_DEPTH, $clog2(DEPTH), pointer width.

Ports:
- CLK  input  1  clock, rising-edge.
- nRST  input  1  asynchronous active-low reset.
- DUT_error  output  1  registered; one-cycle pulse on protocol violation.
- from_fetch_ivalid  input  1  fetch unit offers an instruction this cycle.
- from_fetch_instr  input  32 (word_t)  instruction word.
- from_fetch_PC  input  14 (pc_t)  word-granular PC of the instruction.
- from_fetch_nPC  input  14 (pc_t)  predicted next PC.
- from_pipeline_take_resolved  input  1  flush request from ROB restart.
- to_core_control_full  output  1  queue cannot accept this cycle.
- to_dispatch_valid  output  1  head entry available.
- to_dispatch_instr  output  32  head instruction.
- to_dispatch_PC  output  14  head PC.
- to_dispatch_nPC  output  14  head nPC.
- from_dispatch_ready  input  1  dispatch consumes the head this cycle.
- count_out  output  LOG_DEPTH+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {instr, PC, nPC}, a head pointer, a tail pointer, and a count register. Pointers wrap modulo DEPTH by natural LOG_DEPTH-bit overflow.
- full = (count == DEPTH). Full is derived from state only and does not look ahead to a same-cycle dequeue.
- Enqueue = from_fetch_ivalid & ~full & ~from_pipeline_take_resolved. The entry is written at the tail, then tail advances by 1.
- Dequeue = to_dispatch_valid & from_dispatch_ready & ~from_pipeline_take_resolved. Head advances by 1.
- Count update: next count = count + enqueue − dequeue. Simultaneous enqueue and dequeue leaves count unchanged.
- Empty (count == 0): to_dispatch_valid = 0 and the data outputs show entry[head]. from_dispatch_ready is ignored.
- Flush: when from_pipeline_take_resolved = 1, head, tail and count clear to 0 on the next edge. Flush overrides enqueue and dequeue in the same cycle. Entry contents are not cleared.
- Overflow: from_fetch_ivalid while full is dropped and sets DUT_error = 1 on the next cycle. The controller must stall fetch while full, so this never happens in a correct system.
- Underflow is impossible by construction, because dequeue is gated by valid.

## Timing
- Reset values: head = tail = count = 0, all entries 0, DUT_error = 0, to_dispatch_valid = 0, to_dispatch_instr/PC/nPC = 0, to_core_control_full = 0, count_out = 0.
- Enqueue-to-dispatch latency is 1 cycle when the build runs without bypass: an instruction enqueued at edge N is valid after edge N.
- to_core_control_full rises in the cycle after the DEPTH-th enqueue. It falls in the cycle after the first dequeue from full.
- The flush takes effect at the next edge: to_dispatch_valid = 0 the cycle after take_resolved is sampled high.
- An asynchronous reset mid-operation empties the queue immediately; all outputs take their reset values without waiting for a clock.
- Throughput: one enqueue and one dequeue per cycle sustained.

## Configuration
- INSTR_QUEUE_BYPASS_EN: enables a same-cycle pass-through path when the queue is empty.
- Defined: when count == 0 and from_fetch_ivalid & ~from_pipeline_take_resolved are true:
  - to_dispatch_valid = 1 and the data outputs drive the from_fetch_* values combinationally.
  - If from_dispatch_ready = 1, the instruction is consumed and not written, so count stays 0.
  - Otherwise it is enqueued normally.
- Undefined: no bypass. The outputs come only from stored entries, and the latency is always at least 1 cycle.

## Test plan
- Reset, then 4 back-to-back enqueues (PC 0x10..0x13) with from_dispatch_ready = 0 -> count_out = 4, full = 1; dispatch sees PC 0x10; a fifth ivalid raises DUT_error for exactly one cycle and count stays 4.
- Full queue, ready = 1 for 4 cycles, no ivalid -> dispatch receives PC 0x10, 0x11, 0x12, 0x13 in order; full drops after the first dequeue; valid = 0 after the fourth.
- Steady stream with ivalid = 1 and ready = 1 every cycle for 16 cycles (pointer wraps 4 times) -> every PC appears once, in order, with count_out constant.
- Queue holding 3 entries, pulse take_resolved together with ivalid = 1 and ready = 1 -> next cycle count_out = 0 and valid = 0; the offered instruction is not enqueued and no dequeue is counted.
- Assert nRST low between clock edges with 2 entries held -> valid = 0 and count_out = 0 immediately; the first ivalid after release appears at the head.
- With INSTR_QUEUE_BYPASS_EN, empty queue, ivalid = 1 with instr 0x8C220004, ready = 1 -> to_dispatch_valid = 1 and instr = 0x8C220004 in the same cycle, and count_out stays 0. Without the macro, the same stimulus gives valid in the next cycle.

Source files
------------

// File: rtl/instr_queue.sv
// instr_queue: in-order decoupling FIFO between fetch and dispatch.
// Each entry holds {instr, PC, predicted nPC}. The queue is flushed as a whole
// when the ROB restarts fetch on a resolved target.
// Optional build macro: INSTR_QUEUE_BYPASS_EN adds a same-cycle pass-through
// path from fetch to dispatch while the queue is empty.
module instr_queue #(
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  output logic                 DUT_error,
  input  logic                 from_fetch_ivalid,
  input  logic [31:0]          from_fetch_instr,
  input  logic [13:0]          from_fetch_PC,
  input  logic [13:0]          from_fetch_nPC,
  input  logic                 from_pipeline_take_resolved,
  output logic                 to_core_control_full,
  output logic                 to_dispatch_valid,
  output logic [31:0]          to_dispatch_instr,
  output logic [13:0]          to_dispatch_PC,
  output logic [13:0]          to_dispatch_nPC,
  input  logic                 from_dispatch_ready,
  output logic [LOG_DEPTH:0]   count_out
);

  typedef logic [31:0] word_t;
  typedef logic [13:0] pc_t;

  typedef struct packed {
    word_t instr;
    pc_t   pc;
    pc_t   npc;
  } entry_t;

  entry_t               entries [DEPTH];
  logic [LOG_DEPTH-1:0] head;
  logic [LOG_DEPTH-1:0] tail;
  logic [LOG_DEPTH:0]   count;

  logic   full;
  logic   empty;
  logic   flush;
  logic   bypass_active;
  logic   bypass_take;
  logic   enq;
  logic   deq;
  entry_t head_entry;
  entry_t fetch_entry;

  // Occupancy status and handshake qualification
  always_comb begin
    flush       = from_pipeline_take_resolved;
    full        = (count == (LOG_DEPTH+1)'(DEPTH));
    empty       = (count == '0);
`ifdef INSTR_QUEUE_BYPASS_EN
    bypass_active = empty & from_fetch_ivalid & ~flush;
`else
    bypass_active = 1'b0;
`endif
    // A bypassed instruction that dispatch takes immediately is never stored.
    bypass_take = bypass_active & from_dispatch_ready;
    enq         = from_fetch_ivalid & ~full & ~flush & ~bypass_take;
    // Dequeue only from stored entries; a bypass consumption does not move head.
    deq         = ~empty & from_dispatch_ready & ~flush;
  end

  // Dispatch-side view: head entry, or the live fetch offer when bypassing
  always_comb begin
    head_entry        = entries[head];
    fetch_entry.instr = from_fetch_instr;
    fetch_entry.pc    = from_fetch_PC;
    fetch_entry.npc   = from_fetch_nPC;
    to_dispatch_valid = ~empty | bypass_active;
    if (bypass_active) begin
      to_dispatch_instr = fetch_entry.instr;
      to_dispatch_PC    = fetch_entry.pc;
      to_dispatch_nPC   = fetch_entry.npc;
    end else begin
      to_dispatch_instr = head_entry.instr;
      to_dispatch_PC    = head_entry.pc;
      to_dispatch_nPC   = head_entry.npc;
    end
    to_core_control_full = full;
    count_out            = count;
  end

  // Entry storage; contents survive a flush, only the pointers are cleared
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (enq) begin
      entries[tail] <= fetch_entry;
    end
  end

  // Head/tail pointers and occupancy count
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (deq) head <= head + LOG_DEPTH'(1);
      if (enq) tail <= tail + LOG_DEPTH'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + (LOG_DEPTH+1)'(1);
        2'b01:   count <= count - (LOG_DEPTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Overflow detector: a fetch offer while full is dropped and flagged
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      DUT_error <= 1'b0;
    end else begin
      DUT_error <= from_fetch_ivalid & full;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue using a queue-based reference model.
module tb_instr_queue;

  localparam int DEPTH = 4;
  localparam int LOG_DEPTH = $clog2(DEPTH);

  logic                 CLK;
  logic                 nRST;
  logic                 DUT_error;
  logic                 from_fetch_ivalid;
  logic [31:0]          from_fetch_instr;
  logic [13:0]          from_fetch_PC;
  logic [13:0]          from_fetch_nPC;
  logic                 from_pipeline_take_resolved;
  logic                 to_core_control_full;
  logic                 to_dispatch_valid;
  logic [31:0]          to_dispatch_instr;
  logic [13:0]          to_dispatch_PC;
  logic [13:0]          to_dispatch_nPC;
  logic                 from_dispatch_ready;
  logic [LOG_DEPTH:0]   count_out;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .CLK                         (CLK),
    .nRST                        (nRST),
    .DUT_error                   (DUT_error),
    .from_fetch_ivalid           (from_fetch_ivalid),
    .from_fetch_instr            (from_fetch_instr),
    .from_fetch_PC               (from_fetch_PC),
    .from_fetch_nPC              (from_fetch_nPC),
    .from_pipeline_take_resolved (from_pipeline_take_resolved),
    .to_core_control_full        (to_core_control_full),
    .to_dispatch_valid           (to_dispatch_valid),
    .to_dispatch_instr           (to_dispatch_instr),
    .to_dispatch_PC              (to_dispatch_PC),
    .to_dispatch_nPC             (to_dispatch_nPC),
    .from_dispatch_ready         (from_dispatch_ready),
    .count_out                   (count_out)
  );

  typedef struct {
    logic [31:0] instr;
    logic [13:0] pc;
    logic [13:0] npc;
  } ent_t;

  ent_t sb [$];
  logic exp_err;
  int   n_total;
  int   n_pass;
  logic chk_en;

  // model scratch
  int   m_n;
  logic m_byp;
  ent_t m_e;

  // checker scratch
  logic        c_v;
  logic [31:0] c_instr;
  logic [13:0] c_pc;
  logic [13:0] c_npc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model: updated on the same edge the DUT samples
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sb.delete();
      exp_err = 1'b0;
    end else begin
      m_n   = sb.size();
      m_byp = 1'b0;
`ifdef INSTR_QUEUE_BYPASS_EN
      m_byp = (m_n == 0) && from_fetch_ivalid && !from_pipeline_take_resolved && from_dispatch_ready;
`endif
      exp_err = from_fetch_ivalid && (m_n == DEPTH);
      if (from_pipeline_take_resolved) begin
        sb.delete();
      end else begin
        if (m_n != 0 && from_dispatch_ready) void'(sb.pop_front());
        if (from_fetch_ivalid && m_n < DEPTH && !m_byp) begin
          m_e.instr = from_fetch_instr;
          m_e.pc    = from_fetch_PC;
          m_e.npc   = from_fetch_nPC;
          sb.push_back(m_e);
        end
      end
    end
  end

  // Output checker on the falling edge
  always @(negedge CLK) begin
    if (nRST && chk_en) begin
      c_v = (sb.size() != 0);
      c_instr = '0; c_pc = '0; c_npc = '0;
      if (c_v) begin
        c_instr = sb[0].instr; c_pc = sb[0].pc; c_npc = sb[0].npc;
      end
`ifdef INSTR_QUEUE_BYPASS_EN
      if (!c_v && from_fetch_ivalid && !from_pipeline_take_resolved) begin
        c_v = 1'b1;
        c_instr = from_fetch_instr; c_pc = from_fetch_PC; c_npc = from_fetch_nPC;
      end
`endif
      chk("valid", 32'(to_dispatch_valid), 32'(c_v));
      if (c_v) begin
        chk("instr", to_dispatch_instr, c_instr);
        chk("pc", 32'(to_dispatch_PC), 32'(c_pc));
        chk("npc", 32'(to_dispatch_nPC), 32'(c_npc));
      end
      chk("count", 32'(count_out), 32'(sb.size()));
      chk("full", 32'(to_core_control_full), 32'(sb.size() == DEPTH));
      chk("err", 32'(DUT_error), 32'(exp_err));
    end
  end

  task automatic drive(input logic iv, input logic [13:0] pc, input logic take, input logic rdy);
    @(posedge CLK);
    #1;
    from_fetch_ivalid           = iv;
    from_fetch_PC               = pc;
    from_fetch_nPC              = pc + 14'd1;
    from_fetch_instr            = 32'h1000_0000 | 32'(pc);
    from_pipeline_take_resolved = take;
    from_dispatch_ready         = rdy;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    chk_en  = 1'b0;
    nRST    = 1'b0;
    from_fetch_ivalid = 1'b0;
    from_fetch_instr  = '0;
    from_fetch_PC     = '0;
    from_fetch_nPC    = '0;
    from_pipeline_take_resolved = 1'b0;
    from_dispatch_ready = 1'b0;
    #3;
    chk("rst_valid", 32'(to_dispatch_valid), 32'd0);
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_full", 32'(to_core_control_full), 32'd0);
    chk("rst_err", 32'(DUT_error), 32'd0);
    chk("rst_instr", to_dispatch_instr, 32'd0);
    chk("rst_pc", 32'(to_dispatch_PC), 32'd0);
    chk("rst_npc", 32'(to_dispatch_nPC), 32'd0);
    #9 nRST = 1'b1;
    chk_en = 1'b1;

    // Fill to full, then overflow attempt
    for (int i = 0; i < 4; i++) drive(1'b1, 14'h10 + 14'(i), 1'b0, 1'b0);
    drive(1'b1, 14'h14, 1'b0, 1'b0);
    drive(1'b0, 14'h0, 1'b0, 1'b0);
    chk("t1_count", 32'(count_out), 32'd4);
    chk("t1_pc_head", 32'(to_dispatch_PC), 32'h10);
    drive(1'b0, 14'h0, 1'b0, 1'b0);

    // Drain in order
    for (int i = 0; i < 4; i++) drive(1'b0, 14'h0, 1'b0, 1'b1);
    drive(1'b0, 14'h0, 1'b0, 1'b0);
    chk("t2_empty", 32'(to_dispatch_valid), 32'd0);

    // Sustained stream across several pointer wraps
    for (int i = 0; i < 16; i++) drive(1'b1, 14'h20 + 14'(i), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 14'h0, 1'b0, 1'b1);

    // Flush with 3 entries held, while offering and consuming
    for (int i = 0; i < 3; i++) drive(1'b1, 14'h40 + 14'(i), 1'b0, 1'b0);
    drive(1'b1, 14'h43, 1'b1, 1'b1);
    drive(1'b0, 14'h0, 1'b0, 1'b0);
    chk("t4_count", 32'(count_out), 32'd0);
    chk("t4_valid", 32'(to_dispatch_valid), 32'd0);
    drive(1'b0, 14'h0, 1'b0, 1'b0);

    // Asynchronous reset between edges with 2 entries held
    for (int i = 0; i < 2; i++) drive(1'b1, 14'h50 + 14'(i), 1'b0, 1'b0);
    drive(1'b0, 14'h0, 1'b0, 1'b0);
    @(posedge CLK);
    #1 nRST = 1'b0;
    #1;
    chk("arst_valid", 32'(to_dispatch_valid), 32'd0);
    chk("arst_count", 32'(count_out), 32'd0);
    chk("arst_pc", 32'(to_dispatch_PC), 32'd0);
    #1 nRST = 1'b1;
    drive(1'b1, 14'h55, 1'b0, 1'b0);
    drive(1'b0, 14'h0, 1'b0, 1'b0);
    chk("post_rst_pc", 32'(to_dispatch_PC), 32'h55);
    drive(1'b0, 14'h0, 1'b0, 1'b1);
    drive(1'b0, 14'h0, 1'b0, 1'b0);

    // Offer into an empty queue with dispatch ready
    @(posedge CLK);
    #1;
    from_fetch_ivalid   = 1'b1;
    from_fetch_instr    = 32'h8C22_0004;
    from_fetch_PC       = 14'h60;
    from_fetch_nPC      = 14'h61;
    from_dispatch_ready = 1'b1;
    #2;
`ifdef INSTR_QUEUE_BYPASS_EN
    chk("byp_valid", 32'(to_dispatch_valid), 32'd1);
    chk("byp_instr", to_dispatch_instr, 32'h8C22_0004);
`else
    chk("nobyp_valid", 32'(to_dispatch_valid), 32'd0);
`endif
    drive(1'b0, 14'h0, 1'b0, 1'b1);
`ifdef INSTR_QUEUE_BYPASS_EN
    chk("byp_count", 32'(count_out), 32'd0);
`else
    chk("nobyp_valid_next", 32'(to_dispatch_valid), 32'd1);
    chk("nobyp_instr_next", to_dispatch_instr, 32'h8C22_0004);
`endif
    drive(1'b0, 14'h0, 1'b0, 1'b0);
    drive(1'b0, 14'h0, 1'b0, 1'b0);

    @(posedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
